// File: rtl/bsg_fsb_arb_pkg.sv
// Shared types and defaults for the FSB round-robin burst arbiter.
package bsg_fsb_arb_pkg;

  localparam int fsb_width_default_lp = 80;

  typedef enum logic [0:0] {
    eIDLE  = 1'b0,
    eGRANT = 1'b1
  } fsb_arb_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO used as the registered output buffer of the FSB arbiter.
module bsg_two_fifo
  import bsg_fsb_arb_pkg::*;
#(
  parameter int width_p = fsb_width_default_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               enq;
  logic               deq;

  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[rd_ptr];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + 2'(enq) - 2'(deq);
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/fsb_rr_burst_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one FSB master-input channel
// between several sources; output goes through a two-entry buffer.
module fsb_rr_burst_arbiter
  import bsg_fsb_arb_pkg::*;
#(
  parameter int fsb_width_p = fsb_width_default_lp,
  parameter int num_req_p   = 4,
  parameter int max_burst_p = 8,
  localparam int lg_req_lp  = (num_req_p == 1) ? 1 : $clog2(num_req_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*fsb_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]             req_r_o,
  output logic                             fsb_v_o,
  output logic [fsb_width_p-1:0]           fsb_data_o,
  input  logic                             fsb_r_i,
  output logic                             grant_v_o,
  output logic [lg_req_lp-1:0]             grant_id_o
);

  localparam int cnt_width_lp = $clog2(max_burst_p + 1);

  fsb_arb_state_e          state;
  logic [lg_req_lp-1:0]    owner;
  logic [lg_req_lp-1:0]    last_ptr;
  logic [cnt_width_lp-1:0] burst_cnt;
  logic [lg_req_lp-1:0]    winner;
  logic                    fifo_ready;
  logic                    owner_v;
  logic                    transfer;
  logic                    burst_last;

  assign owner_v    = req_v_i[owner];
  assign transfer   = (state == eGRANT) & owner_v & fifo_ready;
  assign burst_last = (burst_cnt == cnt_width_lp'(max_burst_p - 1));
  assign grant_v_o  = (state == eGRANT);
  assign grant_id_o = owner;

  // Search starts just after the previous owner so every source gets a turn.
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= num_req_p; i++) begin
      int idx;
      idx = (int'(last_ptr) + i) % num_req_p;
      if (!found && req_v_i[idx]) begin
        winner = lg_req_lp'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_r_o = '0;
    if (state == eGRANT) req_r_o[owner] = fifo_ready;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= eIDLE;
      owner     <= '0;
      last_ptr  <= lg_req_lp'(num_req_p - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        eIDLE: begin
          if (|req_v_i) begin
            owner     <= winner;
            last_ptr  <= winner;
            burst_cnt <= '0;
            state     <= eGRANT;
          end
        end
        eGRANT: begin
          // A stalled but still-valid owner keeps the grant; only a full burst
          // or the owner going idle gives it up.
          if (transfer && burst_last) begin
            state <= eIDLE;
          end else if (!owner_v) begin
            state <= eIDLE;
          end else if (transfer) begin
            burst_cnt <= burst_cnt + cnt_width_lp'(1);
          end
        end
        default: state <= eIDLE;
      endcase
    end
  end

  bsg_two_fifo #(
    .width_p(fsb_width_p)
  ) out_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (req_data_i[owner*fsb_width_p +: fsb_width_p]),
    .v_i    (transfer),
    .ready_o(fifo_ready),
    .v_o    (fsb_v_o),
    .data_o (fsb_data_o),
    .yumi_i (fsb_v_o & fsb_r_i)
  );

endmodule
